// File: rtl/jstk_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : jstk_spi_responder
// Description : SPI mode-0 slave emulating the PmodJSTK joystick. Returns a
//               frame {Xlo, Xhi, Ylo, Yhi, btn, 0...} on MISO and decodes the
//               master's first byte into two LED control bits.
// Revision    : 1.0 - initial release
// ============================================================================
module jstk_spi_responder #(
    parameter int NBYTES      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic [2:0] i_btn,
    input  logic       i_ss_n,
    input  logic       i_sclk,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic [1:0] o_leds,
    output logic       o_cmd_valid,
    output logic       o_xfer_done,
    output logic       o_busy
);

    localparam int c_tx_w   = NBYTES * 8;
    localparam int c_byte_w = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_byte_w-1:0] c_last_byte = c_byte_w'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_ss_q;
    logic                   r_sclk_q;

    logic              w_ss_s;
    logic              w_sclk_s;
    logic              w_mosi_s;
    logic              w_ss_fall;
    logic              w_ss_rise;
    logic              w_sclk_rise;
    logic              w_sclk_fall;

    logic [39:0]       w_frame;
    logic [c_tx_w-1:0] w_load;
    logic [c_tx_w-1:0] r_tx;
    logic [6:0]        r_rx;
    logic [2:0]        r_bit_cnt;
    logic [c_byte_w-1:0] r_byte_cnt;

    logic              w_load_en;
    logic              w_rise_en;
    logic              w_fall_en;
    logic              w_cmd_hit;
    logic              w_xfer_end;

    logic              r_miso;
    logic [1:0]        r_leds;
    logic              r_cmd_valid;
    logic              r_xfer_done;

    // Bring the asynchronous SPI pins into the i_clk domain; SS idles high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
        end
    end

    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // Previous synced level of SS and SCLK, used to find edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ss_q   <= 1'b1;
            r_sclk_q <= 1'b0;
        end else begin
            r_ss_q   <= w_ss_s;
            r_sclk_q <= w_sclk_s;
        end
    end

    assign w_ss_fall   = r_ss_q & ~w_ss_s;
    assign w_ss_rise   = ~r_ss_q & w_ss_s;
    assign w_sclk_rise = ~r_sclk_q & w_sclk_s;
    assign w_sclk_fall = r_sclk_q & ~w_sclk_s;

    // Joystick frame as the master expects it: little-endian 10-bit axes.
    assign w_frame = {i_x[7:0], 6'b0, i_x[9:8], i_y[7:0], 6'b0, i_y[9:8], 5'b0, i_btn};

    generate
        if (c_tx_w == 40) begin : g_exact
            assign w_load = w_frame;
        end else if (c_tx_w > 40) begin : g_pad
            assign w_load = {w_frame, {(c_tx_w - 40){1'b0}}};
        end else begin : g_trunc
            assign w_load = w_frame[39 -: c_tx_w];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and datapath strobes; SS rise always beats a same-cycle SCLK edge.
    always_comb begin
        w_next_state = r_state;
        w_load_en    = 1'b0;
        w_rise_en    = 1'b0;
        w_fall_en    = 1'b0;
        w_cmd_hit    = 1'b0;
        w_xfer_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_ss_rise) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_load_en    = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_next_state = ST_IDLE;
                end else begin
                    if (w_sclk_rise) begin
                        w_rise_en = 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_byte_cnt == '0 && r_rx[6:1] == 6'b100000) begin
                                w_cmd_hit = 1'b1;
                            end
                            if (r_byte_cnt == c_last_byte) begin
                                w_next_state = ST_DONE;
                            end
                        end
                    end
                    if (w_sclk_fall) begin
                        w_fall_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (w_ss_rise) begin
                    w_xfer_end   = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_sclk_fall) begin
                    w_fall_en = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Shift registers and bit/byte counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
        end else begin
            if (w_load_en) begin
                r_tx       <= w_load;
                r_rx       <= '0;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
            end else begin
                if (w_rise_en) begin
                    r_rx      <= {r_rx[5:0], w_mosi_s};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end
                end
                if (w_fall_en) begin
                    r_tx <= {r_tx[c_tx_w-2:0], 1'b0};
                end
            end
        end
    end

    // MISO follows the tx MSB one cycle late; held low while idle or loading.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_miso <= 1'b0;
        end else if (r_state == ST_IDLE || r_state == ST_LOAD) begin
            r_miso <= 1'b0;
        end else begin
            r_miso <= r_tx[c_tx_w-1];
        end
    end

    // Command decode and completion pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_leds      <= 2'b00;
            r_cmd_valid <= 1'b0;
            r_xfer_done <= 1'b0;
        end else begin
            r_cmd_valid <= w_cmd_hit;
            r_xfer_done <= w_xfer_end;
            if (w_cmd_hit) begin
                r_leds <= {r_rx[0], w_mosi_s};
            end
        end
    end

    assign o_miso      = r_miso;
    assign o_leds      = r_leds;
    assign o_cmd_valid = r_cmd_valid;
    assign o_xfer_done = r_xfer_done;
    assign o_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
